// File: rtl/spi_flash_responder.sv
`default_nettype none
// ============================================================================
// Module      : spi_flash_responder
// Description : SPI NOR flash responder (mode 0) backed by on-chip memory.
//               Answers JEDEC ID, RDSR, WREN/WRDI, READ, PAGE PROGRAM and
//               SECTOR ERASE so the bootloader sees a flash-like device.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_flash_responder #(
  parameter int          MEM_AW      = 14,
  parameter int          SECTOR_AW   = 12,
  parameter logic [23:0] JEDEC_ID    = 24'hC84016,
  parameter int          PROG_CYCLES = 64
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       spi_csel,
  input  logic       spi_clk,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       wip,
  output logic       wel,
  output logic [7:0] last_cmd
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CMD     = 3'd1;
  localparam logic [2:0] S_ADDR    = 3'd2;
  localparam logic [2:0] S_RD_DATA = 3'd3;
  localparam logic [2:0] S_WR_DATA = 3'd4;
  localparam logic [2:0] S_RESP    = 3'd5;
  localparam logic [2:0] S_IGNORE  = 3'd6;
  localparam logic [2:0] S_ERASE   = 3'd7;

  localparam logic [1:0] OP_READ  = 2'd0;
  localparam logic [1:0] OP_PROG  = 2'd1;
  localparam logic [1:0] OP_ERASE = 2'd2;

  localparam int             PCW       = $clog2(PROG_CYCLES + 1);
  localparam logic [PCW-1:0] PROG_LOAD = PCW'(PROG_CYCLES);

  logic [2:0]              state, state_next;
  logic [1:0]              csel_sync, sclk_sync, mosi_sync;
  logic                    csel_prev, sclk_prev;
  logic [2:0]              bit_cnt;
  logic [6:0]              shift_in;
  logic [1:0]              op;
  logic                    resp_id;
  logic [1:0]              resp_idx;
  logic [1:0]              addr_cnt;
  logic [15:0]             addr_mid;
  logic [MEM_AW-1:0]       rd_addr;
  logic                    pp_written, erase_armed, erase_busy;
  logic [SECTOR_AW-1:0]    erase_cnt;
  logic [MEM_AW-SECTOR_AW-1:0] sector_base;
  logic [PCW-1:0]          prog_cnt;
  logic [7:0]              tx_shift;
  logic [7:0]              rd_data;
  logic [7:0]              resp_byte;
  logic                    mem_we;
  logic [MEM_AW-1:0]       mem_waddr;
  logic [7:0]              mem_wdata;

  // Backing store comes up erased; its contents survive reset.
  logic [7:0] mem [0:(1<<MEM_AW)-1] = '{default: 8'hFF};

  wire       cs_n      = csel_sync[1];
  wire       cs_rise   = csel_sync[1] & ~csel_prev;
  wire       sclk_rise = sclk_sync[1] & ~sclk_prev & ~cs_n;
  wire       sclk_fall = ~sclk_sync[1] & sclk_prev & ~cs_n;
  wire [7:0] rx_byte   = {shift_in, mosi_sync[1]};
  wire       byte_done = sclk_rise && (bit_cnt == 3'd7);
  // Upper address bits beyond the memory size alias onto the array.
  wire [MEM_AW-1:0] addr_full = MEM_AW'({addr_mid, rx_byte});

  assign wip = erase_busy | (prog_cnt != '0);

  // Two-flop synchronizers plus previous-value flops for edge detection.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      csel_sync <= 2'b11;
      sclk_sync <= 2'b00;
      mosi_sync <= 2'b00;
      csel_prev <= 1'b1;
      sclk_prev <= 1'b0;
    end else begin
      csel_sync <= {csel_sync[0], spi_csel};
      sclk_sync <= {sclk_sync[0], spi_clk};
      mosi_sync <= {mosi_sync[0], spi_mosi};
      csel_prev <= csel_sync[1];
      sclk_prev <= sclk_sync[1];
    end
  end

  // Receive shifter; bit counter is held at zero while deselected.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bit_cnt  <= 3'd0;
      shift_in <= 7'd0;
    end else if (cs_n) begin
      bit_cnt  <= 3'd0;
    end else if (sclk_rise) begin
      bit_cnt  <= bit_cnt + 3'd1;
      shift_in <= {shift_in[5:0], mosi_sync[1]};
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_next;
  end

  // FSM next state: opcode decode and address-phase completion.
  always_comb begin
    state_next = state;
    if (cs_n) begin
      state_next = (erase_busy || (cs_rise && erase_armed)) ? S_ERASE : S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_ERASE: state_next = S_CMD;
        S_CMD: begin
          if (byte_done) begin
            if (wip && rx_byte != 8'h05) begin
              state_next = S_IGNORE;
            end else begin
              case (rx_byte)
                8'h9F, 8'h05: state_next = S_RESP;
                8'h03:        state_next = S_ADDR;
                8'h02, 8'h20: state_next = wel ? S_ADDR : S_IGNORE;
                default:      state_next = S_IGNORE;
              endcase
            end
          end
        end
        S_ADDR: begin
          if (byte_done && addr_cnt == 2'd2) begin
            case (op)
              OP_READ: state_next = S_RD_DATA;
              OP_PROG: state_next = S_WR_DATA;
              default: state_next = S_IGNORE;
            endcase
          end
        end
        default: state_next = state;
      endcase
    end
  end

  // FSM outputs: next response byte and memory write port selection.
  always_comb begin
    resp_byte = 8'hFF;
    case (state)
      S_RESP: begin
        if (resp_id) begin
          case (resp_idx)
            2'd0:    resp_byte = JEDEC_ID[23:16];
            2'd1:    resp_byte = JEDEC_ID[15:8];
            2'd2:    resp_byte = JEDEC_ID[7:0];
            default: resp_byte = 8'hFF;
          endcase
        end else begin
          resp_byte = {6'b0, wel, wip};
        end
      end
      S_RD_DATA: resp_byte = rd_data;
      default:   resp_byte = 8'hFF;
    endcase
    mem_we    = erase_busy || (state == S_WR_DATA && byte_done);
    mem_waddr = erase_busy ? {sector_base, erase_cnt} : rd_addr;
    // Programming can only clear bits, hence the AND with the old byte.
    mem_wdata = erase_busy ? 8'hFF : (rd_data & rx_byte);
  end

  // Memory port: one write, one registered read at the current pointer.
  always @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    rd_data <= mem[rd_addr];
  end

  // Command datapath: address capture, status latches, program/erase timers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      op <= OP_READ;  resp_id <= 1'b0;  resp_idx <= 2'd0;  addr_cnt <= 2'd0;
      addr_mid <= 16'd0;  rd_addr <= '0;  pp_written <= 1'b0;
      erase_armed <= 1'b0;  erase_busy <= 1'b0;  erase_cnt <= '0;
      sector_base <= '0;  prog_cnt <= '0;  wel <= 1'b0;  last_cmd <= 8'h00;
    end else begin
      if (prog_cnt != '0) prog_cnt <= prog_cnt - PCW'(1);
      if (erase_busy) begin
        erase_cnt <= erase_cnt + SECTOR_AW'(1);
        if (&erase_cnt) erase_busy <= 1'b0;
      end
      if (cs_rise) begin
        pp_written  <= 1'b0;
        erase_armed <= 1'b0;
        if (pp_written) begin
          wel      <= 1'b0;
          prog_cnt <= PROG_LOAD;
        end
        if (erase_armed) begin
          wel        <= 1'b0;
          erase_busy <= 1'b1;
          erase_cnt  <= '0;
        end
      end else if (byte_done) begin
        case (state)
          S_CMD: begin
            last_cmd <= rx_byte;
            addr_cnt <= 2'd0;
            resp_idx <= 2'd0;
            resp_id  <= (rx_byte == 8'h9F);
            op       <= (rx_byte == 8'h02) ? OP_PROG :
                        (rx_byte == 8'h20) ? OP_ERASE : OP_READ;
            if (!wip && rx_byte == 8'h06) wel <= 1'b1;
            if (!wip && rx_byte == 8'h04) wel <= 1'b0;
          end
          S_ADDR: begin
            addr_mid <= {addr_mid[7:0], rx_byte};
            addr_cnt <= addr_cnt + 2'd1;
            if (addr_cnt == 2'd2) begin
              rd_addr <= addr_full;
              if (op == OP_ERASE) begin
                erase_armed <= 1'b1;
                sector_base <= addr_full[MEM_AW-1:SECTOR_AW];
              end
            end
          end
          S_RD_DATA: rd_addr <= rd_addr + MEM_AW'(1);
          S_WR_DATA: begin
            pp_written <= 1'b1;
            rd_addr    <= {rd_addr[MEM_AW-1:8], rd_addr[7:0] + 8'd1};
          end
          S_RESP: if (resp_idx != 2'd3) resp_idx <= resp_idx + 2'd1;
          default: ;
        endcase
      end
    end
  end

  // MISO shifter: a new byte loads on the fall following the 8th rise.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      spi_miso <= 1'b1;
      tx_shift <= 8'hFF;
    end else if (cs_n) begin
      spi_miso <= 1'b1;
      tx_shift <= 8'hFF;
    end else if (sclk_fall) begin
      if (bit_cnt == 3'd0) begin
        spi_miso <= resp_byte[7];
        tx_shift <= {resp_byte[6:0], 1'b1};
      end else begin
        spi_miso <= tx_shift[7];
        tx_shift <= {tx_shift[6:0], 1'b1};
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/spi_flash_responder.md
# spi_flash_responder

Synthesizable SPI NOR flash responder (mode 0) that answers the command set issued by the bootloader's SPI flash master. It lets `usb_dfu_core` run against an on-chip BRAM image instead of a real flash, for hardware-in-the-loop and simulation of DFU download/upload. It sits on the `flash_csel`/`flash_sclk`/`flash_mosi`/`flash_miso` net in place of the flash device.

## Interface
- `MEM_AW`, 14: byte-address width of the backing memory (16 KiB); upper 24-bit address bits are ignored (aliasing).
- `SECTOR_AW`, 12: sector size for command 0x20 (4 KiB, aligned).
- `JEDEC_ID`, 24'hC84016: bytes returned by 0x9F, MSB first.
- `PROG_CYCLES`, 64: WIP duration after a page program, in `clk` cycles.
- `clk`  in  1  system clock; all logic in this single domain.
- `resetn`  in  1  asynchronous, active-low reset.
- `spi_csel`  in  1  chip select, active low (asynchronous to `clk`).
- `spi_clk`  in  1  SPI clock from master (asynchronous).
- `spi_mosi`  in  1  master-out data (asynchronous).
- `spi_miso`  out  1  responder data, registered; reset 1.
- `wip`  out  1  status bit 0 (write/erase in progress); reset 0.
- `wel`  out  1  status bit 1 (write enable latch); reset 0.
- `last_cmd`  out  8  opcode of the most recent completed command byte; reset 8'h00.

## Operation
- Inputs pass through 2-FF synchronizers; rise/fall of `spi_clk` and rise of `spi_csel` are detected on the synchronized signals.
- MOSI is sampled on `spi_clk` rise. MISO is updated on `spi_clk` fall. A 3-bit bit counter resets on `spi_csel` high.
- States: IDLE, CMD, ADDR (3 bytes, MSB first), RD_DATA, WR_DATA, RESP, IGNORE, ERASE.
- CS low while IDLE: enter CMD. `spi_miso` = 1 until a response byte is loaded.
- The 8th rise in CMD latches the opcode into `last_cmd` and decodes it:
  - 0x9F: RESP; the 3 ID bytes are followed by 0xFF.
  - 0x05: RESP; returns `{6'b0, wel, wip}` repeatedly, with the value refreshed at each byte boundary.
  - 0x06: set `wel`. 0x04: clear `wel`. 0xAB: no-op. All three then go to IGNORE.
  - 0x03: ADDR, then RD_DATA. Each byte is `mem[addr]`; addr increments and wraps modulo 2^MEM_AW.
  - 0x02: requires `wel`=1, else IGNORE. ADDR, then WR_DATA. Each full received byte performs `mem[addr] <= mem[addr] & byte`. Address bits [7:0] increment with wrap inside the 256-byte page.
  - 0x20: requires `wel`=1, else IGNORE. ADDR; the operation is armed when the 3rd address byte completes.
  - Unknown opcodes: IGNORE.
- While `wip`=1, every opcode except 0x05 goes to IGNORE.
- CS rise:
  - The transaction ends and the FSM returns to IDLE. A partial byte is discarded.
  - If at least one PP byte was written: clear `wel`, set `wip` for PROG_CYCLES cycles.
  - If an erase is armed: clear `wel`, set `wip`, enter ERASE. ERASE writes 0xFF to each byte of the aligned sector, one per cycle (2^SECTOR_AW cycles), then clears `wip`.
  - A 0x02/0x20 aborted before completion leaves `wel` unchanged.
- In ERASE, CS transactions are still decoded (only 0x05 is honored).
- Memory is initialized to 0xFF at configuration. Memory contents are not affected by reset.
- Reset mid-operation: FSM returns to IDLE. `wip`, `wel` and the program counter are cleared, and the erase is abandoned with a partial sector.

## Timing
- Constraint: `spi_clk` high and low phases are each ≥ 4 `clk` cycles. CS setup/hold to the first/last edge is ≥ 4 cycles.
- MISO: the response MSB is driven 3 `clk` cycles after the `spi_clk` fall that follows the 8th rise of the preceding byte. Later bits follow each fall with the same 3-cycle latency.
- Memory read latency is 1 cycle. The read is issued on the 8th rise, so the data is ready before the next fall.
- Write commit happens 1 cycle after the 8th rise detect of the data byte.
- `wel`/`last_cmd` update 1 cycle after the 8th-rise detect. `wip` rises 1 cycle after the CS-rise detect.

## Test plan
- Reset, then CS low, 0x9F plus 4 dummy bytes: MISO returns C8 40 16 FF; `last_cmd`=9F.
- 0x05 after reset: returns 00. Then 0x06, then 0x05: returns 02. Then 0x04, then 0x05: returns 00.
- 0x02 000010 AA without WREN: ignored. Then 0x03 000010: returns FF.
- WREN; 0x02 0000FE 11 22 33, then CS high:
  - Reads at 0xFE, 0xFF, 0x00 return 11 22 33 (page wrap).
  - RDSR returns 01 for 64 cycles, then 00.
  - `wel`=0.
- WREN; 0x20 001234, CS high:
  - RDSR polls 01 during 4096 cycles, then 00; a 0x03 issued during WIP returns FF/ignored.
  - Bytes 0x1000–0x1FFF read FF; data at 0x0000 is preserved.
- Reset asserted mid-READ and mid-ERASE: `spi_miso`=1, `wip`=`wel`=0. The next 0x9F transaction works normally.
